// File: rtl/arith_unit_seq.sv
// Multi-cycle unsigned arithmetic unit: single-cycle ADD/SUB, iterative shift-add MUL
// and restoring DIV, with a Busy/Flag handshake toward the ALU controller.
module arith_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           ALU_FUN,
  input  logic                 Arith_Enable,
  output logic [2*WIDTH-1:0]   Arith_OUT,
  output logic                 Carry_OUT,
  output logic                 Arith_Flag,
  output logic                 Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    quot_q, quot_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                carry_q, carry_d;
  logic                flag_q, flag_d;

  logic                accept;
  logic                last_iter;
  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [2*WIDTH-1:0]  acc_step;
  logic [WIDTH:0]      rem_shift;
  logic [WIDTH:0]      rem_sub;
  logic                rem_ge;
  logic [WIDTH-1:0]    rem_step;
  logic [WIDTH-1:0]    quot_step;

  assign accept    = (state_q == IDLE) && Arith_Enable;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign sum       = {1'b0, A} + {1'b0, B};
  assign diff      = {1'b0, A} - {1'b0, B};
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Restoring step: the dividend shifts out of quot_q into the partial remainder
  // while quotient bits shift in from the bottom.
  assign rem_shift = {rem_q, quot_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
  assign rem_sub   = rem_shift - {1'b0, divisor_q};
  assign rem_step  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_step = {quot_q[WIDTH-2:0], rem_ge};

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && ALU_FUN == 2'b10) begin
          state_d = MUL_RUN;
        end else if (accept && ALU_FUN == 2'b11 && B != '0) begin
          state_d = DIV_RUN;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    out_d     = out_q;
    carry_d   = carry_q;
    flag_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (ALU_FUN)
            2'b00: begin
              out_d   = {{(WIDTH-1){1'b0}}, sum};
              carry_d = sum[WIDTH];
              flag_d  = 1'b1;
            end
            2'b01: begin
              out_d   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              carry_d = diff[WIDTH];
              flag_d  = 1'b1;
            end
            2'b10: begin
              mcand_d  = {{WIDTH{1'b0}}, A};
              mplier_d = B;
              acc_d    = '0;
              cnt_d    = '0;
            end
            default: begin
              if (B == '0) begin
                out_d   = '1;
                carry_d = 1'b1;
                flag_d  = 1'b1;
              end else begin
                quot_d    = A;
                divisor_d = B;
                rem_d     = '0;
                cnt_d     = '0;
              end
            end
          endcase
        end
      end
      MUL_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          out_d   = acc_step;
          carry_d = 1'b0;
          flag_d  = 1'b1;
        end
      end
      DIV_RUN: begin
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          out_d   = {rem_step, quot_step};
          carry_d = 1'b0;
          flag_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy       = (state_q != IDLE);
    Arith_OUT  = out_q;
    Carry_OUT  = carry_q;
    Arith_Flag = flag_q;
  end

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
Parametrised, multi-cycle successor to the 8-bit arithmetic unit of the ALU hierarchy. It supports WIDTH-bit unsigned operands:
- ADD and SUB complete in a single cycle.
- MUL uses an iterative shift-add multiplier.
- DIV uses an iterative restoring divider that returns both quotient and remainder.

A Busy/Flag handshake lets the ALU controller issue operations back-to-back without fixed-delay assumptions.

Parameters:
WIDTH, 8, operand width in bits (>= 2); result width is 2*WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
A  input  WIDTH  operand A (unsigned)
B  input  WIDTH  operand B (unsigned)
ALU_FUN  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
Arith_Enable  input  1  request; sampled only when Busy=0
Arith_OUT  output  2*WIDTH  registered result, held until next completion
Carry_OUT  output  1  ADD carry / SUB borrow / DIV divide-by-zero
Arith_Flag  output  1  one-cycle pulse: Arith_OUT/Carry_OUT updated
Busy  output  1  MUL/DIV iteration in progress; requests ignored

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high: RST=1 at a rising edge of clk forces Arith_OUT=0, Carry_OUT=0, Arith_Flag=0, Busy=0, FSM=IDLE and iteration counter=0. Reset overrides everything, including mid-MUL/DIV: the operation is aborted and no Flag is produced.
- Accept: accept edge k is a rising edge with RST=0, Busy=0 and Arith_Enable=1. A, B and ALU_FUN are captured at that edge only. Later changes to them do not affect an accepted operation.
- Arith_Enable while Busy=1: ignored entirely. Nothing is queued.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- ADD (IDLE, edge k):
  - Arith_OUT <= zero-extended (A+B), WIDTH+1 bits significant.
  - Carry_OUT <= sum bit WIDTH.
  - Flag=1 for the cycle after edge k.
  - Stays in IDLE; Busy never asserts.
- SUB (IDLE, edge k):
  - Arith_OUT[WIDTH-1:0] <= (A-B) mod 2^WIDTH; upper bits are 0.
  - Carry_OUT <= 1 if A<B, else 0.
  - Flag as for ADD.
- MUL:
  - Edge k: load multiplicand, multiplier and a 2*WIDTH accumulator, clear the counter, Busy<=1, go to MUL_RUN.
  - Edges k+1..k+WIDTH: one shift-add iteration each.
  - At edge k+WIDTH: Arith_OUT <= A*B (exact, 2*WIDTH bits), Carry_OUT<=0, Flag<=1, Busy<=0, go to IDLE.
- DIV with B!=0:
  - Edge k: load dividend and divisor, clear the remainder, go to DIV_RUN with Busy<=1.
  - Edges k+1..k+WIDTH: one restoring iteration each (shift, trial-subtract, set quotient bit).
  - At edge k+WIDTH: Arith_OUT <= {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, Carry_OUT<=0, Flag<=1, Busy<=0, go to IDLE.
- DIV with B=0: completes at edge k with Arith_OUT <= all ones, Carry_OUT<=1 and Flag for one cycle. Busy never asserts.
- Busy timing: Busy is high exactly WIDTH cycles (after edges k..k+WIDTH-1). The earliest next accept is edge k+WIDTH+1.
- Throughput: ADD/SUB/DBZ accept every cycle. Arith_Flag may stay high over consecutive cycles, one pulse per operation.
- Idle cycles: Arith_Flag=0; Arith_OUT and Carry_OUT hold their last values.
- Invariants: WIDTH-cycle iteration count is fixed for all MUL/DIV operands, with no early termination. The counter is log2(WIDTH)+1 bits wide and wrap-free.

Test Plan:
- Reset/ADD, WIDTH=8: RST=1 for 2 edges, then all outputs are 0. A=15, B=30, ADD, Enable for 1 edge → next cycle Arith_OUT=45, Carry=0, Flag=1; following cycle Flag=0 and 45 held.
- ADD overflow / SUB borrow: A=255, B=1 ADD → Arith_OUT=256, Carry=1. Next edge: A=15, B=50 SUB → Arith_OUT=221, Carry=1 (Flag high both cycles).
- MUL: A=255, B=255 at edge k → Busy=1 for 8 cycles; Flag and Arith_OUT=65025 after edge k+8. Enable held with A=1, B=1, ADD during Busy → ignored; that ADD is accepted at edge k+9 → 2.
- DIV: A=50, B=5 → Arith_OUT=10 (q=10, r=0) after 8 cycles. A=50, B=7 → Arith_OUT=0x0107=263, Carry=0.
- Divide by zero: A=50, B=0 DIV → next cycle Arith_OUT=65535, Carry=1, Flag=1, Busy never high.
- Reset mid-op: start DIV A=200, B=3, assert RST at edge k+4 → all outputs 0, Busy=0, no Flag. A subsequent ADD 2+3 gives 5 normally.
- Parametric: repeat MUL and DIV with WIDTH=16 (A=65535, B=65535 → 4294836225 after 16 cycles; A=1000, B=7 → q=142, r=6).
